// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch: FSM states, digit count, timing defaults.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam int NUM_DIGITS   = 4;
    localparam int DEF_TICK_MAX = 1000000;
    localparam int DEF_SCAN_MAX = 100000;

    // Counter width able to hold 0..max-1, never narrower than one bit.
    function automatic int cnt_width(input int max);
        return (max > 1) ? $clog2(max) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Control pulses in, multiplexed 7-segment digit drive and status out.
interface stopwatch_if;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [3:0] an;
    logic [3:0] bcd;
    logic       dp;
    logic       running;
    logic       lapped;

    modport master (
        output start_stop, lap, clear,
        input  an, bcd, dp, running, lapped
    );

    modport slave (
        input  start_stop, lap, clear,
        output an, bcd, dp, running, lapped
    );
endinterface

// File: rtl/stopwatch_bcd_digit.sv
// One decimal digit of the count: 0..9 with carry out when wrapping from 9.
// Carry is combinational so a whole chain ripples within one cycle.
module bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);
    assign carry = en && (q == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= 4'd0;
        else if (clr)
            q <= 4'd0;
        else if (en)
            q <= carry ? 4'd0 : q + 4'd1;
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch SS.hh: run/pause/lap FSM, prescaled BCD count, 4-digit scanned display.
// Outputs registered (one cycle behind sel/source); inputs are single-cycle pulses, no backpressure.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_MAX = DEF_TICK_MAX,
    parameter int SCAN_MAX = DEF_SCAN_MAX
) (
    input  logic        clk,
    input  logic        reset,
    stopwatch_if.slave  sw
);
    localparam int TW = cnt_width(TICK_MAX);
    localparam int SW = cnt_width(SCAN_MAX);

    state_t                       state, state_n;
    logic [TW-1:0]                presc;
    logic [SW-1:0]                scan;
    logic [1:0]                   sel;
    logic                         active, active_n, tick, scan_wrap;
    logic                         clr_cnt, lap_cap;
    logic [NUM_DIGITS-1:0][3:0]   live, lap_q, disp;
    logic [NUM_DIGITS-1:0]        en, carry;

    // Priority clear > start_stop > lap falls out of the if/else order per state.
    always_comb begin
        state_n = state;
        clr_cnt = 1'b0;
        lap_cap = 1'b0;
        case (state)
            IDLE:  if (sw.start_stop) state_n = RUN;
            RUN: begin
                if (sw.start_stop) state_n = PAUSE;
                else if (sw.lap) begin
                    state_n = LAP;
                    lap_cap = 1'b1;
                end
            end
            LAP: begin
                if (sw.start_stop)  state_n = PAUSE;
                else if (sw.lap)    state_n = RUN;
            end
            PAUSE: begin
                if (sw.clear) begin
                    state_n = IDLE;
                    clr_cnt = 1'b1;
                end else if (sw.start_stop) state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    assign active    = (state == RUN) || (state == LAP);
    assign active_n  = (state_n == RUN) || (state_n == LAP);
    assign tick      = active && (presc == TW'(TICK_MAX - 1));
    assign scan_wrap = (scan == SW'(SCAN_MAX - 1));
    assign disp      = (state == LAP) ? lap_q : live;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            scan       <= '0;
            sel        <= 2'd0;
            lap_q      <= '0;
            sw.an      <= 4'b1110;
            sw.bcd     <= 4'd0;
            sw.dp      <= 1'b1;
            sw.running <= 1'b0;
            sw.lapped  <= 1'b0;
        end else begin
            state <= state_n;
            // Prescaler only free-runs while staying in a counting state, so the
            // first step after a start lands a full TICK_MAX cycles later.
            presc <= (active && active_n) ? (tick ? '0 : presc + 1'b1) : '0;
            scan  <= scan_wrap ? '0 : scan + 1'b1;
            if (scan_wrap) sel <= sel + 2'd1;
            if (lap_cap)   lap_q <= live;
            sw.an      <= ~(4'b0001 << sel);
            sw.bcd     <= disp[sel];
            sw.dp      <= (sel != 2'd2);
            sw.running <= active_n;
            sw.lapped  <= (state_n == LAP);
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign en[i] = tick;
        end else begin : g_chain
            assign en[i] = carry[i-1];
        end
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .en    (en[i]),
            .clr   (clr_cnt),
            .q     (live[i]),
            .carry (carry[i])
        );
    end

    // The top digit's carry only ever fires on the silent 99.99 -> 00.00 wrap.
    a_wrap_from_max: assert property (@(posedge clk) disable iff (reset)
        carry[NUM_DIGITS-1] |-> (live == {NUM_DIGITS{4'd9}}));

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_MAX=4, SCAN_MAX=2 against a count/mode model.
module tb_stopwatch_ctrl;
    localparam int TICK = 4;
    localparam int SCAN = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    stopwatch_if sw ();

    stopwatch_ctrl #(.TICK_MAX(TICK), .SCAN_MAX(SCAN)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    always #5 clk = ~clk;

    // Reference model: hundredths as an integer, plus mode flags.
    int m_count, m_pre, m_lapv;
    bit m_run, m_lap, m_idle;

    function automatic logic [15:0] to_bcd(input int c);
        logic [15:0] r;
        r[3:0]   = 4'(c % 10);
        r[7:4]   = 4'((c / 10) % 10);
        r[11:8]  = 4'((c / 100) % 10);
        r[15:12] = 4'((c / 1000) % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_count = 0; m_pre = 0; m_lapv = 0;
        m_run = 0; m_lap = 0; m_idle = 1;
    endtask

    task automatic model_step(input bit ss, input bit lp, input bit cl);
        int nxt;
        nxt = m_count;
        if (m_run) begin
            if (m_pre == TICK - 1) begin
                nxt   = (m_count + 1) % 10000;
                m_pre = 0;
            end else m_pre++;
        end
        if (m_run) begin
            if (ss) begin
                m_run = 0; m_lap = 0; m_idle = 0;
            end else if (lp) begin
                if (!m_lap) m_lapv = m_count;
                m_lap = !m_lap;
            end
        end else begin
            if (!m_idle && cl) begin
                m_idle = 1; nxt = 0;
            end else if (ss) begin
                m_run = 1; m_idle = 0;
            end
        end
        if (!m_run) m_pre = 0;
        m_count = nxt;
    endtask

    task automatic cyc(input bit ss, input bit lp, input bit cl);
        sw.start_stop = ss; sw.lap = lp; sw.clear = cl;
        @(posedge clk);
        model_step(ss, lp, cl);
        #1;
        sw.start_stop = 0; sw.lap = 0; sw.clear = 0;
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 50000 && m_count != target; i++) cyc(0, 0, 0);
    endtask

    task automatic to_idle();
        if (m_run) cyc(1, 0, 0);
        cyc(0, 0, 1);
    endtask

    // Captures one full scan rotation; reports which slots were seen and dp sanity.
    task automatic read_display(output logic [15:0] v, output logic [3:0] seen, output bit dp_ok);
        v = '0; seen = '0; dp_ok = 1;
        repeat (8) begin
            cyc(0, 0, 0);
            case (sw.an)
                4'b1110: begin v[3:0]   = sw.bcd; seen[0] = 1; end
                4'b1101: begin v[7:4]   = sw.bcd; seen[1] = 1; end
                4'b1011: begin v[11:8]  = sw.bcd; seen[2] = 1; end
                4'b0111: begin v[15:12] = sw.bcd; seen[3] = 1; end
                default: dp_ok = 0;
            endcase
            if (sw.dp !== (sw.an != 4'b1011)) dp_ok = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1; sw.start_stop = 0; sw.lap = 0; sw.clear = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sw.an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b exp 1110", sw.an); end
        checks++; if (sw.bcd !== 4'd0) begin errors++; $display("FAIL reset_bcd got %h exp 0", sw.bcd); end
        checks++; if (sw.dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", sw.dp); end
        checks++; if (sw.running !== 1'b0 || sw.lapped !== 1'b0) begin errors++; $display("FAIL reset_status got %b%b exp 00", sw.running, sw.lapped); end
        checks++; if (dut.live !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp 0000", dut.live); end
        @(negedge clk) reset = 0;
    endtask

    task automatic test_start();
        cyc(1, 0, 0);
        checks++; if (sw.running !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", sw.running); end
        repeat (3) cyc(0, 0, 0);
        checks++; if (dut.live !== 16'h0000) begin errors++; $display("FAIL start_early got %h exp 0000", dut.live); end
        cyc(0, 0, 0);
        checks++; if (dut.live !== 16'h0001) begin errors++; $display("FAIL start_first_tick got %h exp 0001", dut.live); end
        repeat (16) cyc(0, 0, 0);
        checks++; if (dut.live !== 16'h0005) begin errors++; $display("FAIL start_20cyc got %h exp 0005", dut.live); end
        to_idle();
        checks++; if (dut.live !== 16'h0000 || sw.running !== 1'b0) begin errors++; $display("FAIL start_clear got %h/%b exp 0000/0", dut.live, sw.running); end
    endtask

    task automatic test_carry();
        cyc(1, 0, 0);
        run_until(999);
        checks++; if (dut.live !== 16'h0999) begin errors++; $display("FAIL carry_0999 got %h exp 0999", dut.live); end
        run_until(1000);
        checks++; if (dut.live !== 16'h1000) begin errors++; $display("FAIL carry_1000 got %h exp 1000", dut.live); end
        run_until(9999);
        checks++; if (dut.live !== 16'h9999) begin errors++; $display("FAIL carry_9999 got %h exp 9999", dut.live); end
        run_until(0);
        checks++; if (dut.live !== 16'h0000 || sw.running !== 1'b1) begin errors++; $display("FAIL carry_wrap got %h/%b exp 0000/1", dut.live, sw.running); end
        to_idle();
    endtask

    task automatic test_lap();
        logic [15:0] v; logic [3:0] seen; bit dp_ok;
        cyc(1, 0, 0);
        run_until(7);
        cyc(0, 1, 0);
        checks++; if (sw.lapped !== 1'b1 || sw.running !== 1'b1) begin errors++; $display("FAIL lap_enter got %b%b exp 11", sw.running, sw.lapped); end
        read_display(v, seen, dp_ok);
        checks++; if (v !== 16'h0007 || seen !== 4'hF) begin errors++; $display("FAIL lap_frozen got %h/%b exp 0007/1111", v, seen); end
        repeat (4) cyc(0, 0, 0);
        checks++; if (dut.live !== 16'h0010 || dut.live !== to_bcd(m_count)) begin errors++; $display("FAIL lap_live got %h exp 0010", dut.live); end
        cyc(0, 1, 0);
        checks++; if (sw.lapped !== 1'b0 || sw.running !== 1'b1) begin errors++; $display("FAIL lap_exit got %b%b exp 10", sw.running, sw.lapped); end
        cyc(1, 0, 0);
        read_display(v, seen, dp_ok);
        checks++; if (v !== to_bcd(m_count) || !dp_ok) begin errors++; $display("FAIL lap_live_disp got %h exp %h dp_ok %0d", v, to_bcd(m_count), dp_ok); end
        to_idle();
    endtask

    task automatic test_clear_in_run();
        cyc(1, 0, 0);
        repeat (5) cyc(0, 0, 0);
        cyc(0, 0, 1);
        repeat (6) cyc(0, 0, 0);
        checks++; if (sw.running !== 1'b1 || dut.live !== to_bcd(m_count) || m_count == 0) begin errors++; $display("FAIL clear_ignored got %b/%h exp 1/%h", sw.running, dut.live, to_bcd(m_count)); end
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        checks++; if (sw.running !== 1'b0 || dut.live !== 16'h0000) begin errors++; $display("FAIL clear_paused got %b/%h exp 0/0000", sw.running, dut.live); end
    endtask

    task automatic test_simultaneous();
        cyc(1, 0, 0);
        repeat (6) cyc(0, 0, 0);
        cyc(1, 1, 0);
        checks++; if (sw.running !== 1'b0 || sw.lapped !== 1'b0) begin errors++; $display("FAIL ss_lap_prio got %b%b exp 00", sw.running, sw.lapped); end
        // clear+start_stop together in PAUSE: clear wins.
        cyc(1, 0, 1);
        checks++; if (sw.running !== 1'b0 || dut.live !== 16'h0000) begin errors++; $display("FAIL clear_prio got %b/%h exp 0/0000", sw.running, dut.live); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            checks++;
            if (sw.running !== m_run || sw.lapped !== m_lap || dut.live !== to_bcd(m_count)) begin
                errors++;
                if (bad++ < 5) $display("FAIL random cyc %0d got %b%b/%h exp %b%b/%h", i, sw.running, sw.lapped, dut.live, m_run, m_lap, to_bcd(m_count));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_an;
        if (!m_run) cyc(1, 0, 0);
        if (m_lap) cyc(0, 1, 0);
        repeat (10) cyc(0, 0, 0);
        #2 reset = 1;
        model_reset();
        #1;
        checks++; if (sw.an !== 4'b1110 || sw.running !== 1'b0 || dut.live !== 16'h0000 || sw.bcd !== 4'd0) begin errors++; $display("FAIL reset_mid got %b/%b/%h exp 1110/0/0000", sw.an, sw.running, dut.live); end
        @(negedge clk) reset = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0);
            exp_an = 4'b1111;
            exp_an[((k - 1) / SCAN) % 4] = 1'b0;
            checks++; if (sw.an !== exp_an || sw.dp !== (exp_an != 4'b1011)) begin errors++; $display("FAIL scan_seq k=%0d got %b dp %b exp %b", k, sw.an, sw.dp, exp_an); end
        end
        checks++; if (sw.running !== 1'b0 || dut.live !== 16'h0000) begin errors++; $display("FAIL no_resume got %b/%h exp 0/0000", sw.running, dut.live); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_carry();
        test_lap();
        test_clear_in_run();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_MAX, default 1000000, clk cycles per 0.01 s count step.
REQ-002 Parameter SCAN_MAX, default 100000, clk cycles per display digit slot.
REQ-003 clk  in  1  system clock, 100 MHz on board; single clock domain.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 start_stop  in  1  one-cycle pulse, already debounced; toggles running.
REQ-006 lap  in  1  one-cycle pulse; freezes or unfreezes the display.
REQ-007 clear  in  1  one-cycle pulse; zeroes the count when stopped.
REQ-008 an  out  4  active-low anode select, one bit low at a time.
REQ-009 bcd  out  4  BCD value of the digit selected by an, range 0-9.
REQ-010 dp  out  1  active-low decimal point.
REQ-011 running  out  1  high in RUN or LAP.
REQ-012 lapped  out  1  high in LAP.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, PAUSE and LAP.
REQ-014 The FSM SHALL make these transitions: IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; RUN -lap-> LAP; LAP -lap-> RUN; LAP -start_stop-> PAUSE; PAUSE -start_stop-> RUN; PAUSE -clear-> IDLE.
REQ-015 Any input not listed for the current state SHALL be ignored; clear SHALL have no effect in RUN or LAP.
REQ-016 Simultaneous pulses SHALL resolve by priority clear > start_stop > lap; in RUN, start_stop+lap SHALL go to PAUSE without a lap capture.
REQ-017 The count SHALL be four BCD digits d3 d2 d1 d0 (SS.hh), with d0 the hundredths digit.
REQ-018 The prescaler SHALL count 0..TICK_MAX-1 only in RUN or LAP, and SHALL be held at 0 in IDLE and PAUSE.
REQ-019 When the prescaler equals TICK_MAX-1, the count SHALL increment by one on that edge, with the prescaler returning to 0.
REQ-020 The first increment after entering RUN SHALL occur exactly TICK_MAX cycles after the edge that samples start_stop.
REQ-021 Each digit SHALL count 0..9, then wrap to 0 with a carry into the next digit.
REQ-022 The count SHALL wrap 99.99 -> 00.00 silently, with no flag.
REQ-023 The PAUSE -> IDLE transition SHALL zero all four digits on the same edge.
REQ-024 On the RUN -> LAP transition, the live count SHALL be copied into the lap register on the same edge.
REQ-025 The display source SHALL be the lap register in LAP and the live count in all other states.
REQ-026 The live count SHALL keep advancing while in LAP.
REQ-027 The scan counter SHALL count 0..SCAN_MAX-1 continuously, in every state.
REQ-028 On scan counter wrap, sel SHALL advance 0->1->2->3->0.
REQ-029 an SHALL be the inverse of one-hot(sel); bcd SHALL be display digit[sel]; dp SHALL be 0 only when sel==2.
REQ-030 All outputs SHALL be registered, updating one cycle after sel or the source changes.
REQ-031 Every counter compare SHALL use widths of at least clog2 of its MAX value; no truncation is allowed.

Reset
REQ-032 Asserting reset SHALL, asynchronously: set the state to IDLE; zero the prescaler, the scan counter, sel, all digits and the lap register.
REQ-033 While reset is asserted, outputs SHALL be an=4'b1110, bcd=0, dp=1, running=0, lapped=0.
REQ-034 Reset asserted mid-count SHALL discard the count, with no resumption after release.

Structure
REQ-035 Package stopwatch_pkg SHALL hold the state enum, NUM_DIGITS=4, and the default TICK_MAX and SCAN_MAX values.
REQ-036 The design SHALL use one sub-module, bcd_digit (clk, reset, en, clr, q[3:0], carry), instantiated four times in a carry chain.

Verification
REQ-037 The bench SHALL use TICK_MAX=4 and SCAN_MAX=2, and SHALL cover these directed scenarios:
- start_stop pulse from IDLE -> running=1; d0=1 exactly 4 cycles later; d0=5 after 20 cycles.
- Preload via run to 09.99 (d0=9, d1=9, d2=9, d3=0), one tick -> 10.00; from 99.99, one tick -> 00.00.
- Lap at count 00.07, then wait 12 cycles -> display stays 00.07, live count 00.10; second lap -> display 00.10, live.
- In RUN, pulse clear -> ignored, count continues; start_stop then clear -> IDLE with 00.00.
- Same-cycle start_stop+lap in RUN -> PAUSE, lapped=0.
- Reset asserted mid-RUN, between clock edges -> an=1110, running=0, digits 0 immediately; scan sequence 1110, 1101, 1011, 0111 with dp=0 only on 1011.
